// File: rtl/pacman_pkg.sv
// Shared types and default constants for the Pac-Man gameplay blocks.
package pacman_pkg;

  localparam int NUM_GHOSTS       = 4;
  localparam int DEF_FRIGHT_TICKS = 360;
  localparam int DEF_FLASH_TICKS  = 120;
  localparam int DEF_FLASH_PERIOD = 8;
  localparam int DEF_TIMER_W      = 10;
  localparam int COMBO_MAX        = 3;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    FRIGHT = 2'd1,
    FLASH  = 2'd2
  } fright_state_t;

  function automatic logic [1:0] lowest_ghost(input logic [NUM_GHOSTS-1:0] v);
    lowest_ghost = '0;
    for (int i = NUM_GHOSTS - 1; i >= 0; i--) begin
      if (v[i]) lowest_ghost = 2'(i);
    end
  endfunction

endpackage

// File: rtl/fright_timer.sv
// Fright down-counter advancing on tick, plus the flash half-period phase counter.
module fright_timer
  import pacman_pkg::*;
#(
  parameter int FRIGHT_TICKS = DEF_FRIGHT_TICKS,
  parameter int FLASH_TICKS  = DEF_FLASH_TICKS,
  parameter int FLASH_PERIOD = DEF_FLASH_PERIOD,
  parameter int TIMER_W      = DEF_TIMER_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic clear,
  input  logic tick,
  input  logic run,
  input  logic flashing,
  output logic expired,
  output logic in_flash,
  output logic flash
);

  logic [TIMER_W-1:0] count;
  logic [TIMER_W-1:0] count_dec;
  logic [TIMER_W-1:0] phase;
  logic               step;

  assign count_dec = count - TIMER_W'(1);
  assign step      = run & tick & ~load & ~clear & (count != '0);
  assign expired   = step & (count_dec == '0);
  assign in_flash  = step & (count_dec <= TIMER_W'(FLASH_TICKS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      phase <= '0;
      flash <= 1'b0;
    end else if (clear) begin
      count <= '0;
      phase <= '0;
      flash <= 1'b0;
    end else if (load) begin
      count <= TIMER_W'(FRIGHT_TICKS);
      phase <= '0;
      flash <= 1'b0;
    end else if (step) begin
      count <= count_dec;
      if (expired) begin
        phase <= '0;
        flash <= 1'b0;
      end else if (!flashing && in_flash) begin
        // entering flash: start white and count a full half-period
        phase <= TIMER_W'(FLASH_PERIOD);
        flash <= 1'b1;
      end else if (flashing) begin
        if (phase == TIMER_W'(1)) begin
          phase <= TIMER_W'(FLASH_PERIOD);
          flash <= ~flash;
        end else begin
          phase <= phase - TIMER_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/fright_controller.sv
// Power-pellet fright-mode FSM with ghost contact resolution (catch / eat / combo).
module fright_controller
  import pacman_pkg::*;
#(
  parameter int FRIGHT_TICKS = DEF_FRIGHT_TICKS,
  parameter int FLASH_TICKS  = DEF_FLASH_TICKS,
  parameter int FLASH_PERIOD = DEF_FLASH_PERIOD,
  parameter int TIMER_W      = DEF_TIMER_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  game_started,
  input  logic                  tick,
  input  logic                  pellet_collected,
  input  logic [NUM_GHOSTS-1:0] ghost_collision,
  input  logic                  level_complete,
  output logic                  fright_active,
  output logic                  fright_flash,
  output logic [NUM_GHOSTS-1:0] ghost_frightened,
  output logic                  ghost_eaten,
  output logic [1:0]            ghost_eaten_id,
  output logic [1:0]            ghost_eaten_count,
  output logic                  pacman_caught
);

  fright_state_t state, state_next;

  logic [NUM_GHOSTS-1:0] eaten_mask, mask_eff, eaten_eff, threat_vec, hit_vec;
  logic [NUM_GHOSTS-1:0] mask_next, eaten_next;
  logic [1:0]            combo, combo_eff, combo_next, eat_id, id_next, count_next;
  logic                  armed, armed_next, caught_next, eat_next;
  logic                  abort, pellet, catch_hit, eat_hit, expired, in_flash;

  assign abort     = ~game_started | level_complete;
  assign pellet    = pellet_collected & ~abort;
  // a same-cycle pellet refrightens everyone before contact is resolved
  assign mask_eff  = pellet ? '1 : ghost_frightened;
  assign eaten_eff = pellet ? '0 : eaten_mask;
  assign combo_eff = pellet ? 2'd0 : combo;

  assign threat_vec = ghost_collision & ~mask_eff & ~eaten_eff;
  assign catch_hit  = ~abort & (|threat_vec);
  assign hit_vec    = ghost_collision & mask_eff;
  assign eat_hit    = ~abort & ~catch_hit & (|hit_vec);
  assign eat_id     = lowest_ghost(hit_vec);

  assign fright_active = (state != NORMAL);

  fright_timer #(
    .FRIGHT_TICKS(FRIGHT_TICKS),
    .FLASH_TICKS (FLASH_TICKS),
    .FLASH_PERIOD(FLASH_PERIOD),
    .TIMER_W     (TIMER_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (pellet),
    .clear   (abort | catch_hit),
    .tick    (tick),
    .run     (state != NORMAL),
    .flashing(state == FLASH),
    .expired (expired),
    .in_flash(in_flash),
    .flash   (fright_flash)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= NORMAL;
      ghost_frightened  <= '0;
      eaten_mask        <= '0;
      combo             <= 2'd0;
      armed             <= 1'b1;
      pacman_caught     <= 1'b0;
      ghost_eaten       <= 1'b0;
      ghost_eaten_id    <= 2'd0;
      ghost_eaten_count <= 2'd0;
    end else begin
      state             <= state_next;
      ghost_frightened  <= mask_next;
      eaten_mask        <= eaten_next;
      combo             <= combo_next;
      armed             <= armed_next;
      pacman_caught     <= caught_next;
      ghost_eaten       <= eat_next;
      ghost_eaten_id    <= id_next;
      ghost_eaten_count <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    if (abort || catch_hit) begin
      state_next = NORMAL;
    end else if (pellet) begin
      state_next = FRIGHT;
    end else begin
      case (state)
        NORMAL: state_next = NORMAL;
        FRIGHT: begin
          if (expired)       state_next = NORMAL;
          else if (in_flash) state_next = FLASH;
        end
        FLASH:  if (expired) state_next = NORMAL;
        default: state_next = NORMAL;
      endcase
    end
  end

  always_comb begin
    mask_next   = mask_eff;
    eaten_next  = eaten_eff;
    combo_next  = combo_eff;
    armed_next  = 1'b1;
    caught_next = 1'b0;
    eat_next    = 1'b0;
    id_next     = 2'd0;
    count_next  = 2'd0;
    if (abort) begin
      mask_next  = '0;
      eaten_next = '0;
      combo_next = 2'd0;
    end else if (catch_hit) begin
      // held contact keeps the flag low, so only the first cycle loses a life
      mask_next   = '0;
      eaten_next  = '0;
      combo_next  = 2'd0;
      armed_next  = 1'b0;
      caught_next = armed;
    end else begin
      if (eat_hit) begin
        mask_next[eat_id]  = 1'b0;
        eaten_next[eat_id] = 1'b1;
        combo_next = (combo_eff == 2'(COMBO_MAX)) ? combo_eff : combo_eff + 2'd1;
        eat_next   = 1'b1;
        id_next    = eat_id;
        count_next = combo_eff;
      end
      if (expired) begin
        mask_next  = '0;
        eaten_next = '0;
        combo_next = 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_fright_controller.sv
// Self-checking bench: directed scenarios plus random play against a tick-count reference model.
module tb_fright_controller;

  localparam int FT = 360;
  localparam int FL = 120;
  localparam int FP = 8;

  logic       clk, rst_n, game_started, tick, pellet_collected, level_complete;
  logic [3:0] ghost_collision;
  logic       fright_active, fright_flash, ghost_eaten, pacman_caught;
  logic [3:0] ghost_frightened;
  logic [1:0] ghost_eaten_id, ghost_eaten_count;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state: remaining fright ticks, per-ghost flags, combo, catch arm
  int       m_left, m_combo;
  bit [3:0] m_fr, m_eatn;
  bit       m_armed;
  bit       e_caught, e_eat;
  int       e_id, e_cnt;

  fright_controller dut (
    .clk(clk), .rst_n(rst_n), .game_started(game_started), .tick(tick),
    .pellet_collected(pellet_collected), .ghost_collision(ghost_collision),
    .level_complete(level_complete), .fright_active(fright_active),
    .fright_flash(fright_flash), .ghost_frightened(ghost_frightened),
    .ghost_eaten(ghost_eaten), .ghost_eaten_id(ghost_eaten_id),
    .ghost_eaten_count(ghost_eaten_count), .pacman_caught(pacman_caught)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_left = 0; m_combo = 0; m_fr = '0; m_eatn = '0; m_armed = 1'b1;
    e_caught = 1'b0; e_eat = 1'b0; e_id = 0; e_cnt = 0;
  endtask

  function automatic bit exp_flash();
    if (m_left == 0 || m_left > FL) return 1'b0;
    return (((FL - m_left) / FP) % 2) == 0;
  endfunction

  task automatic model_step(input bit gs, input bit tk, input bit pel, input bit lc,
                            input bit [3:0] coll);
    bit [3:0] threat, hits;
    e_caught = 1'b0; e_eat = 1'b0; e_id = 0; e_cnt = 0;
    if (!gs || lc) begin
      m_left = 0; m_fr = '0; m_eatn = '0; m_combo = 0; m_armed = 1'b1;
      return;
    end
    if (pel) begin
      m_left = FT; m_fr = 4'hF; m_eatn = '0; m_combo = 0;
    end else if (tk && m_left > 0) begin
      m_left = m_left - 1;
    end
    threat = coll & ~m_fr & ~m_eatn;
    if (threat != 0) begin
      e_caught = m_armed; m_armed = 1'b0;
      m_left = 0; m_fr = '0; m_eatn = '0; m_combo = 0;
    end else begin
      m_armed = 1'b1;
      hits = coll & m_fr;
      for (int i = 0; i < 4; i++) begin
        if (hits[i] && !e_eat) begin
          e_eat = 1'b1; e_id = i; e_cnt = m_combo;
          m_fr[i] = 1'b0; m_eatn[i] = 1'b1;
          m_combo = (m_combo < 3) ? m_combo + 1 : 3;
        end
      end
      if (m_left == 0) begin
        m_fr = '0; m_eatn = '0; m_combo = 0;
      end
    end
  endtask

  task automatic check_outputs();
    chk("active", 32'(fright_active), 32'(m_left > 0));
    chk("flash", 32'(fright_flash), 32'(exp_flash()));
    chk("frightened", 32'(ghost_frightened), 32'(m_fr));
    chk("caught", 32'(pacman_caught), 32'(e_caught));
    chk("eaten", 32'(ghost_eaten), 32'(e_eat));
    if (e_eat) begin
      chk("eaten_id", 32'(ghost_eaten_id), 32'(e_id));
      chk("eaten_count", 32'(ghost_eaten_count), 32'(e_cnt));
    end
  endtask

  task automatic step(input bit gs, input bit tk, input bit pel, input bit lc,
                      input bit [3:0] coll);
    game_started = gs; tick = tk; pellet_collected = pel;
    level_complete = lc; ghost_collision = coll;
    @(posedge clk);
    #1;
    model_step(gs, tk, pel, lc, coll);
    check_outputs();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_active"}, 32'(fright_active), 0);
    chk({tag, "_flash"}, 32'(fright_flash), 0);
    chk({tag, "_fr"}, 32'(ghost_frightened), 0);
    chk({tag, "_eaten"}, 32'(ghost_eaten), 0);
    chk({tag, "_caught"}, 32'(pacman_caught), 0);
  endtask

  initial begin
    int n_active, rise_at, fall_at, n_caught;
    bit prev_flash;
    rst_n = 1'b0; game_started = 1'b0; tick = 1'b0; pellet_collected = 1'b0;
    level_complete = 1'b0; ghost_collision = '0;
    model_reset();
    #12;
    check_all_zero("reset");
    rst_n = 1'b1;
    step(1, 0, 0, 0, 4'h0);

    // full fright duration and flash timing
    step(1, 0, 1, 0, 4'h0);
    n_active = 0; rise_at = -1; fall_at = -1; prev_flash = 1'b0;
    for (int k = 1; k <= FT; k++) begin
      if (fright_active) n_active++;
      step(1, 1, 0, 0, 4'h0);
      if (fright_flash && !prev_flash && rise_at < 0) rise_at = k;
      if (!fright_flash && prev_flash && fall_at < 0) fall_at = k;
      prev_flash = fright_flash;
    end
    chk("fright_len", 32'(n_active), FT);
    chk("flash_rise_tick", 32'(rise_at), FT - FL);
    chk("flash_toggle_tick", 32'(fall_at), FT - FL + FP);
    chk("end_inactive", 32'(fright_active), 0);

    // combo sequence 2,0,3,1 then re-pellet restarts combo
    step(1, 0, 1, 0, 4'h0);
    step(1, 0, 0, 0, 4'b0100); step(1, 0, 0, 0, 4'h0);
    step(1, 0, 0, 0, 4'b0001); step(1, 0, 0, 0, 4'h0);
    step(1, 0, 0, 0, 4'b1000); step(1, 0, 0, 0, 4'h0);
    step(1, 0, 0, 0, 4'b0010);
    chk("combo_last", 32'(ghost_eaten_count), 3);
    step(1, 0, 0, 0, 4'b0010);
    step(1, 0, 1, 0, 4'h0);
    step(1, 0, 0, 0, 4'b0010);
    chk("combo_restart", 32'(ghost_eaten_count), 0);

    // simultaneous contacts, then same-cycle pellet plus contact
    step(1, 0, 1, 0, 4'h0);
    step(1, 0, 0, 0, 4'b0101);
    step(1, 0, 0, 0, 4'b0101);
    step(1, 0, 0, 0, 4'b0101);
    step(1, 0, 1, 0, 4'b1000);
    chk("same_cycle_count", 32'(ghost_eaten_count), 0);

    // held collision in NORMAL: one life lost per contact episode
    step(1, 0, 0, 1, 4'h0);
    n_caught = 0;
    for (int k = 0; k < 10; k++) begin
      step(1, 0, 0, 0, 4'b0001);
      if (pacman_caught) n_caught++;
    end
    chk("caught_once", 32'(n_caught), 1);
    step(1, 0, 0, 0, 4'h0);
    step(1, 0, 0, 0, 4'b0001);
    chk("caught_rearm", 32'(pacman_caught), 1);
    step(1, 0, 0, 0, 4'h0);

    // pellet late in flash restarts everything; then level_complete aborts
    step(1, 0, 1, 0, 4'h0);
    for (int k = 0; k < FT - 50; k++) step(1, 1, 0, 0, 4'h0);
    step(1, 0, 0, 0, 4'b0010);
    step(1, 0, 1, 0, 4'h0);
    chk("restart_mask", 32'(ghost_frightened), 4'hF);
    chk("restart_flash", 32'(fright_flash), 0);
    step(1, 1, 0, 0, 4'h0);
    step(1, 0, 0, 1, 4'b0100);
    check_all_zero("level_complete");

    // async reset during flash, and pellet ignored when gameplay is off
    step(1, 0, 1, 0, 4'h0);
    for (int k = 0; k < FT - FL + 3; k++) step(1, 1, 0, 0, 4'h0);
    step(1, 0, 0, 0, 4'b1000);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    model_reset();
    #2 rst_n = 1'b1;
    step(0, 1, 1, 0, 4'h0);
    step(0, 0, 0, 0, 4'h0);
    chk("gs_low_pellet", 32'(fright_active), 0);

    // random play
    for (int k = 0; k < 6000; k++) begin
      step(($urandom_range(0, 149) != 0), $urandom_range(0, 1),
           ($urandom_range(0, 299) == 0), ($urandom_range(0, 399) == 0),
           ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fright_controller.md
# fright_controller

Power-pellet fright-mode controller, directly upstream of the score manager. Converts pellet pickups and per-ghost contact into fright-mode status, the per-ghost frightened mask for the ghost renderer and AI, single-cycle ghost-eaten events with the combo index the score manager uses for its 200/400/800/1600 lookup, and a single-cycle Pac-Man-caught event that drives `lose_life`. Sits between the maze/collision logic and `score_manager`.

## Interface
Parameters:
- `FRIGHT_TICKS`, default 360: fright duration in game ticks (6 s at 60 Hz).
- `FLASH_TICKS`, default 120: final portion of fright during which ghosts flash.
- `FLASH_PERIOD`, default 8: ticks per flash half-period.
- `TIMER_W`, default 10: timer width; must hold `FRIGHT_TICKS`.

Ports:
- `clk` input 1: system clock.
- `rst_n` input 1: reset; asynchronous, active-low.
- `game_started` input 1: gameplay enable; low forces the NORMAL state.
- `tick` input 1: one-cycle game-frame strobe; all timers advance only on it.
- `pellet_collected` input 1: one-cycle power-pellet pickup pulse.
- `ghost_collision` input 4: level; bit i is high while Pac-Man overlaps ghost i.
- `level_complete` input 1: pulse; aborts fright.
- `fright_active` output 1: high in FRIGHT or FLASH.
- `fright_flash` output 1: flash phase (1 means draw white); 0 outside FLASH.
- `ghost_frightened` output 4: bit i is high while ghost i is frightened and not yet eaten.
- `ghost_eaten` output 1: one-cycle pulse per ghost eaten.
- `ghost_eaten_id` output 2: index of the eaten ghost; valid with `ghost_eaten`.
- `ghost_eaten_count` output 2: combo index (0 to 3) of this eat; valid with `ghost_eaten`.
- `pacman_caught` output 1: one-cycle pulse; connects to `lose_life`.

## Operation
- States: NORMAL, FRIGHT, FLASH.
- NORMAL to FRIGHT on `pellet_collected`:
  - load timer with `FRIGHT_TICKS`;
  - set `ghost_frightened` to 4'b1111;
  - clear the combo counter to 0.
- Pellet while in FRIGHT or FLASH restarts the same way: timer reloaded, all four ghosts frightened again, combo reset to 0.
- On each `tick` in FRIGHT or FLASH the timer decrements:
  - FRIGHT to FLASH when the decremented value is at most `FLASH_TICKS`;
  - FLASH to NORMAL when it reaches 0, clearing `ghost_frightened`.
- Flash behaviour:
  - `fright_flash` is set to 1 on entry to FLASH;
  - it toggles every `FLASH_PERIOD` ticks (separate phase counter).
- Contact resolution, each cycle, in this priority order:
  - **Catch:** if any set `ghost_collision` bit corresponds to a ghost that is not frightened and was not eaten this fright, `pacman_caught` pulses. No eat occurs that cycle. Fright state is then cleared to NORMAL.
  - **Eat:** otherwise, the lowest-index colliding frightened ghost is eaten:
    - `ghost_eaten` pulses;
    - `ghost_eaten_id` is that index;
    - `ghost_eaten_count` is the combo value before increment;
    - that ghost's `ghost_frightened` bit clears;
    - combo increments, saturating at 3.
  - **Simultaneous contacts:** other simultaneous frightened contacts are eaten on subsequent cycles, one per cycle, provided the collision is still asserted.
- Eaten ghosts (eyes) are ignored by collision until the next pellet or the end of fright.
- Catch arming:
  - `pacman_caught` fires once per contact episode;
  - it re-arms only after one full cycle with no catch-qualifying collision.
  - This prevents multi-life loss from a held collision level.
- `level_complete` or `game_started` low: go to NORMAL. Timer, combo and mask are cleared; no pulses are emitted; catch is re-armed.
- Same-cycle pellet and collision: the pellet is applied first, then contact resolves against the new all-frightened mask. A ghost eaten that same cycle gets count 0.

## Timing
- All outputs are registered; one-cycle latency from input to output.
- Reset values: state NORMAL; timer, combo and flash phase 0; every output 0; catch armed.
- Reset asserted mid-fright returns immediately to these values, asynchronously.
- Without `tick`, the timer holds. Pellet and collision handling does not depend on `tick`.
- Total fright duration: exactly `FRIGHT_TICKS` ticks from the pellet to `fright_active` falling (on the cycle after the final tick).

## Structure
- Shared package `pacman_pkg` holds:
  - state enum `fright_state_t` (NORMAL, FRIGHT, FLASH);
  - `NUM_GHOSTS` = 4;
  - default tick constants.
- One sub-module, `fright_timer`:
  - loadable down-counter with `tick` enable;
  - flash phase counter;
  - outputs `expired` and `in_flash`.
- The FSM, contact priority encoder and catch-arm flag stay in the top module.

## Test plan
- Pellet, then 360 ticks → `fright_active` high for exactly 360 ticks; `fright_flash` first toggles 8 ticks after the 240th tick; `ghost_frightened` goes 1111 then 0000.
- Pellet, then contacts with ghosts 2, 0, 3, 1 in separate cycles → four `ghost_eaten` pulses with count 0, 1, 2, 3 and matching ids; a fifth eat after a re-pellet gives count 0.
- `ghost_collision` = 4'b0101 held during fright → eats id 0 (count 0) then id 2 (count 1) on consecutive cycles; no catch.
- Collision held for 10 cycles in NORMAL → exactly one `pacman_caught` pulse; release for 1 cycle and reassert → a second pulse.
- Pellet at timer = 50 → timer reloads to 360, `fright_flash` goes 0, combo resets, eaten ghosts refrightened; `level_complete` mid-fright → all outputs 0 next cycle.
- `rst_n` low during FLASH → all outputs 0 immediately; pellet with `game_started` = 0 → no response.
